// File: rtl/ysyx_22040931_store_unit_pkg.sv
// Shared definitions for the store path: width codes, AXI response codes and
// the store-unit FSM encoding.
package ysyx_22040931_store_unit_pkg;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_ONE  = 3'b001;
  localparam logic [2:0] W_DOU  = 3'b010;
  localparam logic [2:0] W_FOR  = 3'b011;
  localparam logic [2:0] W_EIG  = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_22040931_store_align.sv
// Byte-lane placement for a store: shifts data and strobe to the address
// offset inside the 64-bit beat and flags misaligned half/word/double.
module ysyx_22040931_store_align
  import ysyx_22040931_store_unit_pkg::*;
(
  input  logic [2:0]  memwop,
  input  logic [2:0]  off,
  input  logic [63:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [2:0]  awsize,
  output logic        misalign
);

  logic [7:0] mask;

  always_comb begin
    mask     = 8'h00;
    awsize   = 3'd0;
    misalign = 1'b0;
    case (memwop)
      W_ONE: begin
        mask = 8'h01;
      end
      W_DOU: begin
        mask     = 8'h03;
        awsize   = 3'd1;
        misalign = off[0];
      end
      W_FOR: begin
        mask     = 8'h0f;
        awsize   = 3'd2;
        misalign = |off[1:0];
      end
      W_EIG: begin
        mask     = 8'hff;
        awsize   = 3'd3;
        misalign = |off;
      end
      default: ;
    endcase
    // Bits pushed past the top of the beat are simply dropped.
    wdata = data << {off, 3'b000};
    wstrb = mask << off;
  end

endmodule

// File: rtl/ysyx_22040931_store_unit.sv
// Store LSU stage: accepts one store, runs a single AXI4-lite write
// (AW/W/B) and pulses completion or fault back to pipeline control.
module ysyx_22040931_store_unit
  import ysyx_22040931_store_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_memwop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done_valid,
  output logic              done_fault,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are
  // both high; valid, once raised, holds with stable payload until then.

  state_t            state, state_d;
  logic              aw_pend, aw_d;
  logic              w_pend, w_d;
  logic              fault, fault_d;
  logic              latch_en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic [2:0]        size_q;

  logic [63:0]       al_wdata;
  logic [7:0]        al_wstrb;
  logic [2:0]        al_size;
  logic              al_misalign;
  logic              illegal;

  ysyx_22040931_store_align u_align (
    .memwop   (req_memwop),
    .off      (req_addr[2:0]),
    .data     (req_data),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .awsize   (al_size),
    .misalign (al_misalign)
  );

  assign illegal = (req_memwop > W_EIG);

  always_comb begin
    state_d  = state;
    aw_d     = aw_pend;
    w_d      = w_pend;
    fault_d  = fault;
    latch_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          if (req_memwop == W_NONE) begin
            state_d = ST_DONE;
            fault_d = 1'b0;
          end else if (illegal || al_misalign) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_SEND;
            aw_d    = 1'b1;
            w_d     = 1'b1;
            fault_d = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (aw_pend && awready) aw_d = 1'b0;
        if (w_pend && wready)   w_d  = 1'b0;
        if (!aw_d && !w_d)      state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (bvalid) begin
          fault_d = (bresp != RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      fault   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
    end else begin
      state   <= state_d;
      aw_pend <= aw_d;
      w_pend  <= w_d;
      fault   <= fault_d;
      if (latch_en) begin
        addr_q  <= req_addr;
        wdata_q <= al_wdata;
        wstrb_q <= al_wstrb;
        size_q  <= al_size;
      end
    end
  end

  // req_ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready  = (state == ST_IDLE) && rst_n;
  assign done_valid = (state == ST_DONE);
  assign done_fault = (state == ST_DONE) && fault;
  assign awvalid    = aw_pend;
  assign wvalid     = w_pend;
  assign bready     = (state == ST_WAIT_B);
  assign awaddr     = addr_q;
  assign awsize     = size_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign dbg_state  = state;

endmodule
